// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: requester IDs and default widths.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  // Starve counter width covers the full legal STARVE_LIMIT range (1..15).
  localparam int unsigned STARVE_W   = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_GPU  = 2'd2
  } req_id_e;

  // Saturating increment for the starve counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val);
    return (val == STARVE_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/GPU) arbiter for a single synchronous-RAM port. GPU has
// priority; a starved CPU is forced through after STARVE_LIMIT wait cycles.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // GPU requester
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_gnt,
  output logic              gpu_rvalid,
  output logic [DATA_W-1:0] gpu_rdata,
  // Shared memory port
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  req_id_e             sel;
  logic [STARVE_W-1:0] starve_q, starve_d;
  // rd_pend_q[0] = CPU read outstanding, rd_pend_q[1] = GPU read outstanding
  logic [1:0]          rd_pend_q, rd_pend_d;
  logic                cpu_starved;

  assign cpu_starved = 32'(starve_q) >= STARVE_LIMIT;

  // Pick the winner for this cycle; reset blocks every grant.
  always_comb begin
    sel = REQ_NONE;
    if (!reset) begin
      if (cpu_req && gpu_req) begin
        sel = cpu_starved ? REQ_CPU : REQ_GPU;
      end else if (gpu_req) begin
        sel = REQ_GPU;
      end else if (cpu_req) begin
        sel = REQ_CPU;
      end
    end
  end

  // Grants and shared memory port steering; idle port is driven to zero.
  always_comb begin
    cpu_gnt   = 1'b0;
    gpu_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (sel)
      REQ_CPU: begin
        cpu_gnt   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      REQ_GPU: begin
        gpu_gnt   = 1'b1;
        mem_we    = gpu_we;
        mem_addr  = gpu_addr;
        mem_wdata = gpu_wdata;
      end
      default: ;
    endcase
  end

  // Next-state for the starve counter and read-pending flags.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req || cpu_gnt) begin
      starve_d = '0;
    end else begin
      starve_d = sat_inc(starve_q);
    end
    rd_pend_d = {gpu_gnt && !gpu_we, cpu_gnt && !cpu_we};
  end

  // State registers with synchronous reset; a pending read is dropped at reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q  <= '0;
      rd_pend_q <= '0;
    end else begin
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Read return: RAM data is passed through only in the rvalid cycle.
  always_comb begin
    cpu_rvalid = rd_pend_q[0] && !reset;
    gpu_rvalid = rd_pend_q[1] && !reset;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    gpu_rdata  = gpu_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous RAM model.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, gpu_req, gpu_we;
  logic [15:0] cpu_addr, cpu_wdata, gpu_addr, gpu_wdata;
  logic        cpu_gnt, cpu_rvalid, gpu_gnt, gpu_rvalid;
  logic [15:0] cpu_rdata, gpu_rdata;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .DATA_W      (16),
    .ADDR_W      (16),
    .STARVE_LIMIT(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .gpu_req   (gpu_req),
    .gpu_we    (gpu_we),
    .gpu_addr  (gpu_addr),
    .gpu_wdata (gpu_wdata),
    .gpu_gnt   (gpu_gnt),
    .gpu_rvalid(gpu_rvalid),
    .gpu_rdata (gpu_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous RAM: contents preloaded while reset is high, read-before-write.
  logic [15:0] ram [256];
  always @(posedge clock) begin
    if (reset) begin
      ram[8'h10] <= 16'h1111;
      ram[8'h20] <= 16'h2222;
      ram[8'h40] <= 16'h1234;
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    gpu_req = 0; gpu_we = 0; gpu_addr = 0; gpu_wdata = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
    check({tag, "_gpu_gnt"}, 32'(gpu_gnt), 0);
    check({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
    check({tag, "_gpu_rvalid"}, 32'(gpu_rvalid), 0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
    check({tag, "_gpu_rdata"}, 32'(gpu_rdata), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  // Expected winner pattern with both requesting and STARVE_LIMIT=4: G G G G C G
  logic exp_cpu_win [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    idle_inputs();
    reset = 1;
    // Reset with both requesting a write: everything must stay quiet.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0055; cpu_wdata = 16'hAAAA;
    gpu_req = 1; gpu_we = 1; gpu_addr = 16'h0066; gpu_wdata = 16'h5555;
    next_cycle();
    @(negedge clock);
    check_all_zero("rst");
    next_cycle();

    // CPU-only read, first cycle out of reset.
    reset = 0;
    idle_inputs();
    cpu_req = 1; cpu_addr = 16'h0040;
    @(negedge clock);
    check("r28_cpu_gnt", 32'(cpu_gnt), 1);
    check("r28_gpu_gnt", 32'(gpu_gnt), 0);
    check("r28_mem_addr", 32'(mem_addr), 32'h40);
    check("r28_mem_we", 32'(mem_we), 0);
    check("r28_no_early_rvalid", 32'(cpu_rvalid), 0);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    check("r28_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("r28_cpu_rdata", 32'(cpu_rdata), 32'h1234);
    check("r28_gpu_rvalid", 32'(gpu_rvalid), 0);
    check("r28_idle_addr", 32'(mem_addr), 0);
    next_cycle();
    @(negedge clock);
    check("r28_rvalid_one_cycle", 32'(cpu_rvalid), 0);
    check("r28_rdata_zero", 32'(cpu_rdata), 0);
    next_cycle();

    // Both request continuously: starvation forces the CPU in on cycle 5.
    cpu_req = 1; cpu_addr = 16'h0010;
    gpu_req = 1; gpu_addr = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("r29_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'(exp_cpu_win[i]));
      check($sformatf("r29_gpu_gnt_%0d", i), 32'(gpu_gnt), 32'(!exp_cpu_win[i]));
      check($sformatf("r29_addr_%0d", i), 32'(mem_addr),
            exp_cpu_win[i] ? 32'h10 : 32'h20);
      if (i > 0) begin
        check($sformatf("r29_cpu_rvalid_%0d", i), 32'(cpu_rvalid), 32'(exp_cpu_win[i-1]));
        check($sformatf("r29_gpu_rvalid_%0d", i), 32'(gpu_rvalid), 32'(!exp_cpu_win[i-1]));
        check($sformatf("r29_rdata_%0d", i),
              exp_cpu_win[i-1] ? 32'(cpu_rdata) : 32'(gpu_rdata),
              exp_cpu_win[i-1] ? 32'h1111 : 32'h2222);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clock);
    check("r29_tail_gpu_rvalid", 32'(gpu_rvalid), 1);
    check("r29_tail_gpu_rdata", 32'(gpu_rdata), 32'h2222);
    check("r29_tail_cpu_rdata", 32'(cpu_rdata), 0);
    next_cycle();

    // CPU write then GPU read of the same address.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h00A0; cpu_wdata = 16'hBEEF;
    @(negedge clock);
    check("r30_cpu_gnt", 32'(cpu_gnt), 1);
    check("r30_mem_we", 32'(mem_we), 1);
    check("r30_mem_addr", 32'(mem_addr), 32'hA0);
    check("r30_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    next_cycle();
    idle_inputs();
    gpu_req = 1; gpu_addr = 16'h00A0;
    @(negedge clock);
    check("r30_gpu_gnt", 32'(gpu_gnt), 1);
    check("r30_mem_we_rd", 32'(mem_we), 0);
    check("r30_no_cpu_rvalid_a", 32'(cpu_rvalid), 0);
    next_cycle();
    idle_inputs();
    @(negedge clock);
    check("r30_gpu_rvalid", 32'(gpu_rvalid), 1);
    check("r30_gpu_rdata", 32'(gpu_rdata), 32'hBEEF);
    check("r30_no_cpu_rvalid_b", 32'(cpu_rvalid), 0);
    check("r30_mem_we_idle", 32'(mem_we), 0);
    next_cycle();

    // GPU read granted, then reset the next cycle: the read is dropped.
    gpu_req = 1; gpu_addr = 16'h0020;
    @(negedge clock);
    check("r31_gpu_gnt", 32'(gpu_gnt), 1);
    next_cycle();
    reset = 1;
    cpu_req = 1; cpu_addr = 16'h0010;
    @(negedge clock);
    check_all_zero("r31_in_rst");
    next_cycle();
    reset = 0;
    idle_inputs();
    @(negedge clock);
    check_all_zero("r31_after_rst");
    check("r31_starve", 32'(dut.starve_q), 0);
    next_cycle();

    // CPU request withdrawn after 2 cycles while the GPU holds the port.
    gpu_req = 1; gpu_addr = 16'h0020;
    cpu_req = 1; cpu_addr = 16'h0077;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) cpu_req = 0;
      @(negedge clock);
      check($sformatf("r32_cpu_gnt_%0d", i), 32'(cpu_gnt), 0);
      check($sformatf("r32_gpu_gnt_%0d", i), 32'(gpu_gnt), 1);
      check($sformatf("r32_addr_%0d", i), 32'(mem_addr), 32'h20);
      check($sformatf("r32_starve_%0d", i), 32'(dut.starve_q),
            (i == 3) ? 0 : i);
      next_cycle();
    end
    idle_inputs();
    @(negedge clock);
    check("r32_starve_final", 32'(dut.starve_q), 0);
    check("r32_no_cpu_rvalid", 32'(cpu_rvalid), 0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
